// File: rtl/uart_rx_if.sv
// Byte delivery channel of the UART receiver: held byte, status flags and the
// consumer's ready. The receiver drives it through the master modport.
interface uart_rx_if;
  logic [7:0] rx_data_out;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output rx_data_out,
    output rx_valid,
    output rx_parity_err,
    output rx_frame_err,
    output rx_overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out,
    input  rx_valid,
    input  rx_parity_err,
    input  rx_frame_err,
    input  rx_overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, even parity, stop. Delivers each
// byte over a valid/ready channel with parity, framing and overrun flags.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_data_in,
  output logic      rx_busy,
  uart_rx_if.master rx
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'((HALF > 0) ? HALF - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity_bit;
  logic          armed;
  logic          tick;
  logic          start_det;
  logic          deliver;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    tick       = (baud_cnt == '0);
    start_det  = (state == IDLE) && armed && !rx_data_in;
    deliver    = (state == STOP) && tick;
    next_state = state;
    case (state)
      // When the start sample point falls on the detection edge itself,
      // START has nothing left to check and is skipped.
      IDLE:    if (start_det) next_state = (HALF == 0) ? DATA : START;
      START:   if (tick) next_state = rx_data_in ? IDLE : DATA;
      DATA:    if (tick && bit_idx == 3'd7) next_state = PARITY;
      PARITY:  if (tick) next_state = STOP;
      STOP:    if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rx_busy = (state != IDLE);
  end

  // baud_cnt counts down to the next sample point; a sample is taken when it is zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt         <= '0;
      bit_idx          <= '0;
      shift            <= '0;
      parity_bit       <= 1'b0;
      armed            <= 1'b0;
      rx.rx_data_out   <= '0;
      rx.rx_valid      <= 1'b0;
      rx.rx_parity_err <= 1'b0;
      rx.rx_frame_err  <= 1'b0;
      rx.rx_overrun    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        bit_idx <= '0;
        if (rx_data_in) armed <= 1'b1;
        if (start_det) baud_cnt <= (HALF == 0) ? BIT_RELOAD : HALF_RELOAD;
      end else begin
        baud_cnt <= tick ? BIT_RELOAD : baud_cnt - 1'b1;
      end

      if (state == DATA && tick) begin
        shift   <= {rx_data_in, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      if (state == PARITY && tick) parity_bit <= rx_data_in;

      // A low stop bit may be the start of a break; require idle before re-arming.
      if (deliver && !rx_data_in) armed <= 1'b0;

      if (deliver) begin
        rx.rx_data_out   <= shift;
        rx.rx_parity_err <= (^shift) ^ parity_bit;
        rx.rx_frame_err  <= ~rx_data_in;
        rx.rx_valid      <= 1'b1;
        if (rx.rx_valid) rx.rx_overrun <= ~rx.rx_ready;
      end else if (rx.rx_valid && rx.rx_ready) begin
        rx.rx_valid   <= 1'b0;
        rx.rx_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 and 4 clocks per bit with hand-computed
// frames, parity bits and expected outputs.
module tb_uart_rx;

  logic clk = 1'b0;
  logic reset;
  logic line1, line4;
  logic busy1, busy4;
  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_rx_if bus1 ();
  uart_rx_if bus4 ();

  uart_rx #(.CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .rx_data_in (line1),
    .rx_busy    (busy1),
    .rx         (bus1)
  );

  uart_rx #(.CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .rx_data_in (line4),
    .rx_busy    (busy4),
    .rx         (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic stop);
    return {stop, p, d, 1'b0};
  endfunction

  // Drives bits[first..last] onto the chosen line, cpb cycles each, changing on negedges.
  task automatic send_bits(input int which, input logic [10:0] bits, input int cpb,
                           input int first, input int last, input bit pulse_ready);
    for (int k = first; k <= last; k++) begin
      if (which == 1) line1 = bits[k];
      else            line4 = bits[k];
      if (pulse_ready && k == 10) bus1.rx_ready = 1'b1;
      repeat (cpb) @(negedge clk);
      bus1.rx_ready = 1'b0;
    end
  endtask

  task automatic accept(input int which);
    if (which == 1) bus1.rx_ready = 1'b1;
    else            bus4.rx_ready = 1'b1;
    @(negedge clk);
    bus1.rx_ready = 1'b0;
    bus4.rx_ready = 1'b0;
  endtask

  initial begin
    bit busy_seen;
    reset = 1'b1;
    line1 = 1'b1;
    line4 = 1'b1;
    bus1.rx_ready = 1'b0;
    bus4.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 8'(bus1.rx_valid), 8'h00);
    check("rst_data", bus1.rx_data_out, 8'h00);
    check("rst_perr", 8'(bus1.rx_parity_err), 8'h00);
    check("rst_ferr", 8'(bus1.rx_frame_err), 8'h00);
    check("rst_ovr", 8'(bus1.rx_overrun), 8'h00);
    check("rst_busy", 8'(busy1), 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 8'hAD: five ones, so even parity bit is 1
    send_bits(1, frame(8'hAD, 1'b1, 1'b1), 1, 0, 9, 1'b0);
    check("ad_valid_early", 8'(bus1.rx_valid), 8'h00);
    check("ad_busy", 8'(busy1), 8'h01);
    send_bits(1, frame(8'hAD, 1'b1, 1'b1), 1, 10, 10, 1'b0);
    check("ad_valid", 8'(bus1.rx_valid), 8'h01);
    check("ad_data", bus1.rx_data_out, 8'hAD);
    check("ad_perr", 8'(bus1.rx_parity_err), 8'h00);
    check("ad_ferr", 8'(bus1.rx_frame_err), 8'h00);
    accept(1);
    check("ad_accept", 8'(bus1.rx_valid), 8'h00);
    check("ad_hold", bus1.rx_data_out, 8'hAD);

    // 8'h3C has correct parity 0; send 1
    send_bits(1, frame(8'h3C, 1'b1, 1'b1), 1, 0, 10, 1'b0);
    check("3c_data", bus1.rx_data_out, 8'h3C);
    check("3c_perr", 8'(bus1.rx_parity_err), 8'h01);
    check("3c_ferr", 8'(bus1.rx_frame_err), 8'h00);
    accept(1);

    // 8'h55 with stop 0, then the line stays low (break)
    send_bits(1, frame(8'h55, 1'b0, 1'b0), 1, 0, 10, 1'b0);
    check("55_valid", 8'(bus1.rx_valid), 8'h01);
    check("55_data", bus1.rx_data_out, 8'h55);
    check("55_ferr", 8'(bus1.rx_frame_err), 8'h01);
    check("55_perr", 8'(bus1.rx_parity_err), 8'h00);
    accept(1);
    busy_seen = 1'b0;
    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      if (busy1) busy_seen = 1'b1;
    end
    check("break_busy", 8'(busy_seen), 8'h00);
    check("break_valid", 8'(bus1.rx_valid), 8'h00);
    line1 = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(1, frame(8'h01, 1'b1, 1'b1), 1, 0, 10, 1'b0);
    check("01_data", bus1.rx_data_out, 8'h01);
    check("01_ferr", 8'(bus1.rx_frame_err), 8'h00);
    check("01_perr", 8'(bus1.rx_parity_err), 8'h00);
    accept(1);

    // Back-to-back with no consumer: overrun
    send_bits(1, frame(8'h11, 1'b0, 1'b1), 1, 0, 10, 1'b0);
    send_bits(1, frame(8'h22, 1'b0, 1'b1), 1, 0, 10, 1'b0);
    check("b2b_data", bus1.rx_data_out, 8'h22);
    check("b2b_ovr", 8'(bus1.rx_overrun), 8'h01);
    check("b2b_valid", 8'(bus1.rx_valid), 8'h01);
    accept(1);
    check("b2b_ovr_clr", 8'(bus1.rx_overrun), 8'h00);
    check("b2b_valid_clr", 8'(bus1.rx_valid), 8'h00);

    // Second pair: ready pulsed on the second delivery edge
    send_bits(1, frame(8'h11, 1'b0, 1'b1), 1, 0, 10, 1'b0);
    send_bits(1, frame(8'h22, 1'b0, 1'b1), 1, 0, 10, 1'b1);
    check("same_edge_ovr", 8'(bus1.rx_overrun), 8'h00);
    check("same_edge_valid", 8'(bus1.rx_valid), 8'h01);
    check("same_edge_data", bus1.rx_data_out, 8'h22);
    accept(1);

    // 4 clks/bit: one-cycle glitch
    line4 = 1'b0;
    @(negedge clk);
    line4 = 1'b1;
    check("glitch_busy_start", 8'(busy4), 8'h01);
    repeat (3) @(negedge clk);
    check("glitch_busy_end", 8'(busy4), 8'h00);
    check("glitch_valid", 8'(bus4.rx_valid), 8'h00);
    send_bits(4, frame(8'hF0, 1'b0, 1'b1), 4, 0, 10, 1'b0);
    check("f0_valid", 8'(bus4.rx_valid), 8'h01);
    check("f0_data", bus4.rx_data_out, 8'hF0);
    check("f0_perr", 8'(bus4.rx_parity_err), 8'h00);
    check("f0_ferr", 8'(bus4.rx_frame_err), 8'h00);
    accept(4);
    check("f0_accept", 8'(bus4.rx_valid), 8'h00);

    // Reset after four data bits, line low through release
    send_bits(1, frame(8'hA5, 1'b0, 1'b1), 1, 0, 4, 1'b0);
    reset = 1'b1;
    line1 = 1'b0;
    @(negedge clk);
    check("midrst_data", bus1.rx_data_out, 8'h00);
    check("midrst_busy", 8'(busy1), 8'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_nodet_busy", 8'(busy1), 8'h00);
    check("midrst_nodet_valid", 8'(bus1.rx_valid), 8'h00);
    line1 = 1'b1;
    repeat (2) @(negedge clk);
    send_bits(1, frame(8'hA5, 1'b0, 1'b1), 1, 0, 10, 1'b0);
    check("a5_valid", 8'(bus1.rx_valid), 8'h01);
    check("a5_data", bus1.rx_data_out, 8'hA5);
    check("a5_perr", 8'(bus1.rx_parity_err), 8'h00);
    check("a5_ferr", 8'(bus1.rx_frame_err), 8'h00);
    check("a5_ovr", 8'(bus1.rx_overrun), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
